// File: rtl/fft_peak_detect.sv
// Scans one half of an FFT spectrum RAM and reports the bin with the largest
// squared magnitude, using a read -> square -> compare pipeline.
module fft_peak_detect #(
  parameter int N      = 1024,
  parameter int M      = 10,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  output logic               rd_en,
  output logic [M-1:0]       rd_addr,
  input  logic signed [31:0] rd_re,
  input  logic signed [31:0] rd_im,
  output logic               Busy,
  output logic               Done,
  output logic [M-1:0]       peak_bin,
  output logic [63:0]        peak_mag
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [M-1:0] LO    = M'(BIN_LO);
  localparam logic [M-1:0] HI    = M'(BIN_HI);
  localparam logic [M-1:0] AMASK = M'(N - 1);

  logic [1:0]   state;
  logic         drain_cnt;
  logic         v_rd;
  logic         v_mag;
  logic [M-1:0] a_rd;
  logic [M-1:0] tag;
  logic [63:0]  mag;

  logic signed [63:0] re_x;
  logic signed [63:0] im_x;
  logic signed [63:0] re_sq;
  logic signed [63:0] im_sq;
  logic [63:0]        sq;

  // Each square is at most 2^62, so the 64-bit sum never wraps.
  always_comb begin
    re_x  = {{32{rd_re[31]}}, rd_re};
    im_x  = {{32{rd_im[31]}}, rd_im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    sq    = $unsigned(re_sq) + $unsigned(im_sq);
  end

  assign rd_en = (state == S_SCAN);
  assign Busy  = (state == S_SCAN) || (state == S_DRAIN);
  assign Done  = (state == S_DONE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      rd_addr   <= '0;
      v_rd      <= 1'b0;
      v_mag     <= 1'b0;
      a_rd      <= '0;
      tag       <= '0;
      mag       <= '0;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      v_rd  <= rd_en;
      a_rd  <= rd_addr;
      v_mag <= v_rd;
      if (v_rd) begin
        mag <= sq;
        tag <= a_rd;
      end
      // Strict compare keeps the lowest bin on ties.
      if (v_mag && (mag > peak_mag)) begin
        peak_mag <= mag;
        peak_bin <= tag;
      end
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_SCAN;
            rd_addr  <= LO;
            peak_mag <= '0;
            peak_bin <= LO;
            v_rd     <= 1'b0;
            v_mag    <= 1'b0;
          end
        end
        S_SCAN: begin
          if (rd_addr == HI) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            rd_addr <= (rd_addr + 1'b1) & AMASK;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_DONE;
        end
        S_DONE: begin
          if (Ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: spectrum RAM model, timing/peak reference
// model checked every cycle, plus directed literal expectations.
module tb_fft_peak_detect;

  localparam int M  = 10;
  localparam int LO = 1;
  localparam int HI = 511;
  localparam int K  = HI - LO + 1;

  logic               clk = 1'b0;
  logic               Reset = 1'b0;
  logic               Start = 1'b0;
  logic               Ack = 1'b0;
  logic               rd_en;
  logic [M-1:0]       rd_addr;
  logic signed [31:0] rd_re = '0;
  logic signed [31:0] rd_im = '0;
  logic               Busy;
  logic               Done;
  logic [M-1:0]       peak_bin;
  logic [63:0]        peak_mag;

  logic signed [31:0] re_mem [0:1023];
  logic signed [31:0] im_mem [0:1023];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  fft_peak_detect #(.N(1024), .M(M), .BIN_LO(LO), .BIN_HI(HI)) dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im),
    .Busy(Busy), .Done(Done), .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) begin
      rd_re <= re_mem[rd_addr];
      rd_im <= im_mem[rd_addr];
    end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: time since accepted Start plus the exhaustive answer.
  int           t = -1;
  bit           m_done = 1'b0;
  logic [M-1:0] e_bin, o_bin = '0;
  logic [63:0]  e_mag, o_mag = '0;

  task automatic scan_expect();
    logic [63:0] m;
    longint r, i;
    e_bin = M'(LO);
    e_mag = '0;
    for (int b = LO; b <= HI; b++) begin
      r = longint'(re_mem[b]);
      i = longint'(im_mem[b]);
      m = 64'(r * r) + 64'(i * i);
      if (m > e_mag) begin
        e_mag = m;
        e_bin = M'(b);
      end
    end
  endtask

  always @(posedge clk) begin
    if (!Reset) begin
      t = -1; m_done = 1'b0; o_bin = '0; o_mag = '0;
    end else if (t >= 0) begin
      t++;
      if (t == K + 2) begin
        t = -1; m_done = 1'b1; o_bin = e_bin; o_mag = e_mag;
      end
    end else if (m_done) begin
      if (Ack) m_done = 1'b0;
    end else if (Start) begin
      t = 0;
      scan_expect();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(Busy), 64'(t >= 0));
      chk("done", 64'(Done), 64'(m_done));
      chk("rd_en", 64'(rd_en), 64'(t >= 0 && t < K));
      if (t >= 0)
        chk("rd_addr", 64'(rd_addr), 64'(LO + ((t < K) ? t : K - 1)));
      else begin
        chk("peak_bin_hold", 64'(peak_bin), 64'(o_bin));
        chk("peak_mag_hold", peak_mag, o_mag);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      re_mem[i] = '0;
      im_mem[i] = '0;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (Done) break;
    end
    if (!Done) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk) Ack = 1'b1;
    @(posedge clk);
    #1 Ack = 1'b0;
    @(negedge clk);
    chk("ack_idle", 64'(Done), 64'd0);
  endtask

  task automatic run_scan(input string tag, input int ebin,
                          input logic [63:0] emag);
    int n;
    start_pulse();
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd513);
    chk({tag, "_bin"}, 64'(peak_bin), 64'(ebin));
    chk({tag, "_mag"}, peak_mag, emag);
    do_ack();
    chk({tag, "_bin_held"}, 64'(peak_bin), 64'(ebin));
  endtask

  initial begin
    int n;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_peak_mag", peak_mag, 64'd0);
    Reset = 1'b1;
    @(negedge clk);

    re_mem[37] = 32'sd1000;
    im_mem[37] = -32'sd1000;
    run_scan("tone", 37, 64'd2000000);

    clear_mem();
    re_mem[0]   = 32'sd30000;
    re_mem[100] = 32'sd500; im_mem[100] = 32'sd500;
    re_mem[200] = 32'sd500; im_mem[200] = 32'sd500;
    run_scan("tie", 100, 64'd500000);

    clear_mem();
    re_mem[511] = 32'sh80000000;
    im_mem[511] = 32'sh80000000;
    re_mem[512] = 32'sh7fffffff;
    run_scan("extreme", 511, 64'h8000_0000_0000_0000);

    // Start held through the whole scan, then Start+Ack together in DONE.
    @(negedge clk) Start = 1'b1;
    @(posedge clk);
    wait_done(n);
    chk("held_latency", 64'(n), 64'd513);
    chk("held_bin", 64'(peak_bin), 64'd511);
    Ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; Ack = 1'b0;
    chk("startack_idle", 64'(Done | Busy), 64'd0);
    chk("startack_mag", peak_mag, 64'h8000_0000_0000_0000);
    clear_mem();
    re_mem[5] = 32'sd3; im_mem[5] = -32'sd4;
    start_pulse();
    @(negedge clk);
    chk("restart_clear", peak_mag, 64'd0);
    wait_done(n);
    chk("restart_bin", 64'(peak_bin), 64'd5);
    chk("restart_mag", peak_mag, 64'd25);
    do_ack();

    // Reset mid-scan at bin 200.
    clear_mem();
    re_mem[37] = 32'sd1000; im_mem[37] = -32'sd1000;
    start_pulse();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (rd_addr == M'(200)) break;
    end
    chk("mid_addr", 64'(rd_addr), 64'd200);
    Reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_addr", 64'(rd_addr), 64'd0);
    chk("mid_rst_bin", 64'(peak_bin), 64'd0);
    chk("mid_rst_mag", peak_mag, 64'd0);
    Reset = 1'b1;
    run_scan("post_rst", 37, 64'd2000000);

    clear_mem();
    run_scan("zero", 1, 64'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
